seg7_scan_display: RTL and testbench
====================================

Name: seg7_scan_display

Overview:
Parametrised multi-digit 7-segment display driver.
- Accepts a binary value through a valid/ready handshake.
- Converts it to BCD sequentially (double dabble, one bit per cycle).
- Time-multiplexes DIGITS digits with a programmable refresh prescaler.
- Sits between the CPU output register and the board segment/digit-select pins. It supersedes the fixed 3-digit combinational BCD plus hand-written scan logic.

Parameters:
- DIGITS, 4: number of digits scanned (2..8).
- BIN_W, 8: width of the binary input value (1..27).
- REFRESH_DIV, 65536: clk cycles each digit stays selected (>=2).
- DIG_ACTIVE_LOW, 1: 1 means dig_sel is driven low for the selected digit (common cathode via low-side select).
- SEG_ACTIVE_LOW, 0: 1 means the seg outputs are inverted.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- value_in, input, BIN_W: binary value to display.
- value_valid, input, 1: value_in is valid this cycle.
- value_ready, output, 1: block can accept a value (high only in IDLE).
- busy, output, 1: conversion in progress.
- overflow, output, 1: last committed value exceeds 10^DIGITS-1.
- seg, output, 7: segment pattern, {a,b,c,d,e,f,g}, seg[6]=a.
- dig_sel, output, DIGITS: digit select, one-hot per DIG_ACTIVE_LOW. Bit 0 is the ones digit.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - State is IDLE, value_ready=1, busy=0, overflow=0.
  - The display register is cleared to BCD 0.
  - The prescaler and digit index are cleared.
  - dig_sel is all-inactive and seg is all-off (both honour the polarity parameters).
- Converter FSM:
  - IDLE: value_ready=1. On value_valid && value_ready at edge T, latch value_in, clear the BCD shift register and the overflow accumulator, and go to CONV.
  - CONV: runs BIN_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift left one bit, with the binary MSB entering the BCD LSB. Any 1 shifted out of the top nibble sets the overflow accumulator. Go to COMMIT after the BIN_W-th shift.
  - COMMIT: one cycle. Copy the BCD result and the overflow accumulator into the display register and the overflow output atomically, then return to IDLE.
- Latency: the new value is visible in the display register after edge T+BIN_W+1. value_ready is low from T+1 through T+BIN_W+1.
- value_valid while not ready is ignored. There is no queueing; the producer must hold or re-present the value.
- busy = (state != IDLE).
- Scanner:
  - The prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On terminal count the digit index moves to the next lower digit: DIGITS-1, DIGITS-2, ..., 0, then wraps to DIGITS-1. The most significant digit is scanned first.
  - seg and dig_sel are registered and change on the same edge.
  - The first edge after reset release drives digit DIGITS-1.
- Decode:
  - BCD 0-9 maps to standard patterns.
  - If overflow=1, every digit shows a dash (g only).
  - Nibble codes 10-15 cannot occur; if they do, decode them as blank.
- Reset mid-conversion aborts the conversion. The display returns to 0 and the partial result is never committed.
- Conversion and scanning run independently. A commit takes effect on the digit currently scanned at the next output register update, with no glitch beyond one cycle.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: zero digits above the most significant non-zero digit are blanked (seg all-off while that digit is selected; dig_sel still scans). The ones digit is never blanked, so value 0 shows a single "0". Overflow dashes are not blanked.
- Undefined: all digits are shown, including leading zeros.

Decomposition:
- Package seg7_pkg holds:
  - The 7-bit segment constants for 0-9, SEG_DASH and SEG_BLANK.
  - The converter state enum {IDLE, CONV, COMMIT}.
  - A function that converts DIGITS to the BCD width (4*DIGITS).
- Sub-module bin2bcd_seq holds the sequential double-dabble converter: FSM, handshake and overflow accumulator. It is parametrised by BIN_W and DIGITS.
- The top module keeps the prescaler, digit index, blanking and decode/output registers.

Test Plan:
Unless noted, DIGITS=4, BIN_W=8, REFRESH_DIV=4, active-low digits.
1. Release reset; 32 cycles with no input -> dig_sel sequence 0111, 1011, 1101, 1110, each held 4 cycles. Segments show 0,0,0,0 (or blank,blank,blank,0 with SEG7_LEADING_ZERO_BLANK_EN).
2. value_in=255 with a valid pulse at T -> value_ready low T+1..T+9. Display shows 0,2,5,5 from T+10. overflow=0.
3. DIGITS=2, value_in=100 -> overflow=1 after commit; both digits show g only. Then value_in=99 -> overflow=0, display shows 9,9.
4. Hold value_valid high with value_in changing during CONV -> only the value sampled at the accepting edge is displayed. The next acceptance occurs on the first IDLE cycle.
5. Accept 200, then assert reset at T+4 -> outputs go inactive immediately (asynchronously). After release, display shows 0 and 200 never appears.
6. With SEG7_LEADING_ZERO_BLANK_EN, value 7 -> digits 3..1 blank, digit 0 shows 7. Value 1005 (BIN_W=11) -> 1,0,0,5 with no blanking.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the scanned 7-segment display driver.
// Segment patterns are ordered {a,b,c,d,e,f,g}, so bit 6 is segment a.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    // One BCD nibble per displayed digit.
    function automatic int bcd_width(input int digits);
        return 4 * digits;
    endfunction

    // Active-high segment pattern for one BCD nibble; codes 10-15 show blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready intake.
// One bit per cycle; the finished result and its overflow flag are copied to
// the display register together in a single COMMIT cycle.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      value_in,
    input  logic                  value_valid,
    output logic                  value_ready,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BCD_W = bcd_width(DIGITS);
    localparam int CNT_W = (BIN_W < 2) ? 1 : $clog2(BIN_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    conv_state_t       r_state;
    conv_state_t       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIN_W-1:0]  r_bin;
    logic [BCD_W-1:0]  r_bcd;
    logic              r_ovf_acc;
    logic [BCD_W-1:0]  r_disp;
    logic              r_ovf;
    logic [BCD_W-1:0]  w_adj;
    logic              w_accept;

    assign w_accept = value_ready & value_valid;
    assign busy     = (r_state != IDLE);
    assign bcd_out  = r_disp;
    assign overflow = r_ovf;

    // Next-state and handshake decode for the converter FSM.
    always_comb begin
        w_state_nxt = r_state;
        value_ready = 1'b0;
        case (r_state)
            IDLE: begin
                value_ready = 1'b1;
                if (value_valid) w_state_nxt = CONV;
            end
            CONV: begin
                if (r_cnt == LAST_CNT) w_state_nxt = COMMIT;
            end
            COMMIT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Add-3 correction on every nibble that would reach 10 or more after the shift.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    // Control state plus the committed display value; reset aborts any conversion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_disp  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CONV) r_cnt <= r_cnt + CNT_W'(1);
            else                 r_cnt <= '0;
            if (r_state == COMMIT) begin
                r_disp <= r_bcd;
                r_ovf  <= r_ovf_acc;
            end
        end
    end

    // Shift datapath: load on accept, one double-dabble step per CONV cycle.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_bin     <= value_in;
            r_bcd     <= '0;
            r_ovf_acc <= 1'b0;
        end else if (r_state == CONV) begin
            r_bin     <= r_bin << 1;
            r_bcd     <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
            r_ovf_acc <= r_ovf_acc | w_adj[BCD_W-1];
        end
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Multi-digit 7-segment display driver: sequential BCD conversion feeding a
// time-multiplexed scanner, most significant digit first.
// Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int BIN_W          = 8,
    parameter int REFRESH_DIV    = 65536,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BIN_W-1:0]  value_in,
    input  logic              value_valid,
    output logic              value_ready,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig_sel
);

    localparam int BCD_W = bcd_width(DIGITS);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};
    localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};

    logic [BCD_W-1:0]  w_disp;
    logic              w_ovf;
    logic [PRE_W-1:0]  r_pre;
    logic [IDX_W-1:0]  r_idx;
    logic              w_tc;
    logic [IDX_W-1:0]  w_digit;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic [DIGITS-1:0] w_lz;
    logic [DIGITS-1:0] w_onehot;
    logic [6:0]        w_pat;
    logic [6:0]        r_seg;
    logic [DIGITS-1:0] r_dig;

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk         (clk),
        .reset       (reset),
        .value_in    (value_in),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .busy        (busy),
        .bcd_out     (w_disp),
        .overflow    (w_ovf)
    );

    assign overflow = w_ovf;
    assign seg      = r_seg;
    assign dig_sel  = r_dig;
    assign w_tc     = (r_pre == PRE_W'(REFRESH_DIV - 1));
    // r_idx counts scan positions; position 0 is the top digit.
    assign w_digit  = IDX_W'(DIGITS - 1) - r_idx;

    // Refresh prescaler and scan position, advancing once per terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else begin
            r_pre <= w_tc ? '0 : r_pre + PRE_W'(1);
            if (w_tc) r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic w_zero_above;

    // Mark digits sitting above the most significant non-zero digit; ones digit never blanks.
    always_comb begin
        w_lz         = '0;
        w_zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above & (w_disp[4*i +: 4] == 4'd0);
            w_lz[i]      = w_zero_above;
        end
    end
`else
    assign w_lz = '0;
`endif

    // Select the nibble, blank flag and one-hot select for the scanned digit.
    always_comb begin
        w_nib    = 4'd0;
        w_blank  = 1'b0;
        w_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == w_digit) begin
                w_nib       = w_disp[4*i +: 4];
                w_blank     = w_lz[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Pattern priority: overflow dash, then leading-zero blank, then the digit.
    always_comb begin
        w_pat = seg_decode(w_nib);
        if (w_ovf)        w_pat = SEG_DASH;
        else if (w_blank) w_pat = SEG_BLANK;
    end

    // Segment and digit-select registers update together, honouring pin polarity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg <= SEG_OFF;
            r_dig <= DIG_OFF;
        end else begin
            r_seg <= SEG_ACTIVE_LOW ? ~w_pat : w_pat;
            r_dig <= DIG_ACTIVE_LOW ? ~w_onehot : w_onehot;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: three instances (4 digits/8 bits,
// 2 digits/8 bits, 4 digits/11 bits), all with REFRESH_DIV=4, active-low digits.
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  v0, v1;
    logic [10:0] v2;
    logic        vv0, vv1, vv2;
    logic        rdy0, rdy1, rdy2, busy0, busy1, busy2, ovf0, ovf1, ovf2;
    logic [6:0]  seg0, seg1, seg2;
    logic [3:0]  dig0, dig2;
    logic [1:0]  dig1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seg7_scan_display #(.DIGITS(4), .BIN_W(8), .REFRESH_DIV(4)) u_dut0 (
        .clk(clk), .reset(rst), .value_in(v0), .value_valid(vv0), .value_ready(rdy0),
        .busy(busy0), .overflow(ovf0), .seg(seg0), .dig_sel(dig0));

    seg7_scan_display #(.DIGITS(2), .BIN_W(8), .REFRESH_DIV(4)) u_dut1 (
        .clk(clk), .reset(rst), .value_in(v1), .value_valid(vv1), .value_ready(rdy1),
        .busy(busy1), .overflow(ovf1), .seg(seg1), .dig_sel(dig1));

    seg7_scan_display #(.DIGITS(4), .BIN_W(11), .REFRESH_DIV(4)) u_dut2 (
        .clk(clk), .reset(rst), .value_in(v2), .value_valid(vv2), .value_ready(rdy2),
        .busy(busy2), .overflow(ovf2), .seg(seg2), .dig_sel(dig2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] get_dig(input int w);
        if (w == 0) return {4'b0, dig0};
        if (w == 1) return {6'b0, dig1};
        return {4'b0, dig2};
    endfunction

    function automatic logic [6:0] get_seg(input int w);
        if (w == 0) return seg0;
        if (w == 1) return seg1;
        return seg2;
    endfunction

    function automatic logic get_rdy(input int w);
        if (w == 0) return rdy0;
        if (w == 1) return rdy1;
        return rdy2;
    endfunction

    // Expected active-low select for digit d of an nd-digit display.
    function automatic logic [7:0] exp_dig(input int d, input int nd);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < nd; i++) m[i] = (i != d);
        return m;
    endfunction

    // Expected segments for digit d of value v on an nd-digit display.
    function automatic logic [6:0] exp_seg(input int v, input int d, input int nd);
        int p;
        int lim;
        p   = 1;
        lim = 1;
        for (int i = 0; i < d; i++)  p   = p * 10;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        if (v >= lim) return 7'b0000001;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (d != 0 && v < p) return 7'b0000000;
`endif
        case ((v / p) % 10)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            default: return 7'b1111011;
        endcase
    endfunction

    // Present one value with a single valid pulse and wait for the converter to idle.
    task automatic send(input int w, input int val);
        bit done;
        case (w)
            0: begin v0 = 8'(val);  vv0 = 1'b1; end
            1: begin v1 = 8'(val);  vv1 = 1'b1; end
            default: begin v2 = 11'(val); vv2 = 1'b1; end
        endcase
        tick();
        vv0 = 1'b0; vv1 = 1'b0; vv2 = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            tick();
            if (get_rdy(w)) done = 1'b1;
        end
        chk("send_done", done, 1'b1);
    endtask

    // Lock onto the top digit, then check one full scan frame of selects and segments.
    task automatic scan_check(input int w, input int v, input string tag);
        int nd;
        int d;
        logic [7:0] top, prev, cur;
        bit found;
        nd    = (w == 1) ? 2 : 4;
        top   = exp_dig(nd - 1, nd);
        prev  = get_dig(w);
        found = 1'b0;
        for (int n = 0; n < 64 && !found; n++) begin
            tick();
            cur = get_dig(w);
            if (cur == top && prev != top) found = 1'b1;
            else prev = cur;
        end
        chk({tag, "_sync"}, found, 1'b1);
        for (int k = 0; k < nd * 4; k++) begin
            if (k != 0) tick();
            d = nd - 1 - k / 4;
            chk({tag, "_dig"}, get_dig(w), exp_dig(d, nd));
            chk({tag, "_seg"}, get_seg(w), exp_seg(v, d, nd));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int d;
        rst = 1'b1;
        v0 = '0; v1 = '0; v2 = '0;
        vv0 = 1'b0; vv1 = 1'b0; vv2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", rdy0, 1'b1);
        chk("rst_busy",  busy0, 1'b0);
        chk("rst_ovf",   ovf0, 1'b0);
        chk("rst_dig",   dig0, 4'b1111);
        chk("rst_seg",   seg0, 7'b0000000);
        rst = 1'b0;

        // Idle scan after release: digit 3 first, each held 4 cycles.
        for (int c = 0; c < 32; c++) begin
            tick();
            d = 3 - (c / 4) % 4;
            chk("idle_dig", dig0, exp_dig(d, 4));
            chk("idle_seg", seg0, exp_seg(0, d, 4));
        end

        // 255: handshake timing, then display 0,2,5,5.
        v0 = 8'd255; vv0 = 1'b1;
        tick();
        vv0 = 1'b0;
        chk("c255_ready_T", rdy0, 1'b0);
        chk("c255_busy_T",  busy0, 1'b1);
        repeat (8) tick();
        chk("c255_ready_T8", rdy0, 1'b0);
        chk("c255_busy_T8",  busy0, 1'b1);
        tick();
        chk("c255_ready_T9", rdy0, 1'b1);
        chk("c255_busy_T9",  busy0, 1'b0);
        chk("c255_ovf",      ovf0, 1'b0);
        scan_check(0, 255, "c255");

        // Two-digit overflow then recovery.
        send(1, 100);
        chk("d2_ovf100", ovf1, 1'b1);
        scan_check(1, 100, "d2_100");
        send(1, 99);
        chk("d2_ovf99", ovf1, 1'b0);
        scan_check(1, 99, "d2_99");

        // Valid held while the input changes during conversion.
        v0 = 8'd45; vv0 = 1'b1;
        tick();
        chk("hold_acc", rdy0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            v0 = 8'(100 + i);
            tick();
        end
        chk("hold_conv", rdy0, 1'b0);
        tick();
        vv0 = 1'b0;
        chk("hold_idle", rdy0, 1'b1);
        scan_check(0, 45, "hold45");

        // Continuous valid: next acceptance on the first IDLE cycle.
        v0 = 8'd77; vv0 = 1'b1;
        tick();
        v0 = 8'd99;
        repeat (9) tick();
        chk("reacc_idle", rdy0, 1'b1);
        tick();
        chk("reacc_taken", rdy0, 1'b0);
        vv0 = 1'b0;
        repeat (9) tick();
        chk("reacc_done", rdy0, 1'b1);
        scan_check(0, 99, "reacc99");

        // Small value (leading-zero case) and an 11-bit value.
        send(0, 7);
        scan_check(0, 7, "v7");
        send(2, 1005);
        chk("w11_ovf", ovf2, 1'b0);
        scan_check(2, 1005, "v1005");

        // Reset mid-conversion: outputs go inactive at once, 200 never committed.
        v0 = 8'd200; vv0 = 1'b1;
        tick();
        vv0 = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_dig",   dig0, 4'b1111);
        chk("abort_seg",   seg0, 7'b0000000);
        chk("abort_ready", rdy0, 1'b1);
        chk("abort_busy",  busy0, 1'b0);
        chk("abort_ovf1",  ovf1, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) tick();
        chk("abort_idle", busy0, 1'b0);
        scan_check(0, 0, "abort0");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
